// File: rtl/cpu_bus_pkg.sv
// Shared encodings and widths for the CPU-side SRAM bus arbiter.
// Imported by the arbiter and available to any bus-side neighbours.
package cpu_bus_pkg;

   localparam int CPU_ADDR_W = 32;
   localparam int CPU_DATA_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   function automatic int strb_w(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Merges the core's inst and data SRAM ports onto one bus,
// one transaction in flight, data first with an inst starvation guard.
module sram_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_W       = CPU_ADDR_W,
   parameter int DATA_W       = CPU_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        inst_req,
   input  logic [ADDR_W-1:0]           inst_addr,
   output logic                        inst_addr_ok,
   output logic                        inst_data_ok,
   output logic [DATA_W-1:0]           inst_rdata,
   input  logic                        data_req,
   input  logic                        data_wr,
   input  logic [strb_w(DATA_W)-1:0]   data_wstrb,
   input  logic [ADDR_W-1:0]           data_addr,
   input  logic [DATA_W-1:0]           data_wdata,
   output logic                        data_addr_ok,
   output logic                        data_data_ok,
   output logic [DATA_W-1:0]           data_rdata,
   output logic                        bus_req,
   output logic                        bus_wr,
   output logic [strb_w(DATA_W)-1:0]   bus_wstrb,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [DATA_W-1:0]           bus_wdata,
   input  logic                        bus_addr_ok,
   input  logic                        bus_data_ok,
   input  logic [DATA_W-1:0]           bus_rdata,
   output logic                        bus_err
);

   localparam int SW = strb_w(DATA_W);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [1:0]        r_state;
   logic              r_owner;
   logic [CW-1:0]     r_starve;
   logic              r_bus_req;
   logic              r_bus_wr;
   logic [SW-1:0]     r_bus_wstrb;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic [DATA_W-1:0] r_inst_rdata;
   logic [DATA_W-1:0] r_data_rdata;
   logic              r_inst_dok;
   logic              r_data_dok;
   logic              r_bus_err;

   logic w_idle;
   logic w_force;
   logic w_gnt_i;
   logic w_gnt_d;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_force = inst_req & (r_starve == LIM);
   assign w_gnt_d = w_idle & data_req & ~w_force;
   assign w_gnt_i = w_idle & inst_req & (~data_req | w_force);

   assign inst_addr_ok = w_gnt_i;
   assign data_addr_ok = w_gnt_d;
   assign inst_data_ok = r_inst_dok;
   assign data_data_ok = r_data_dok;
   assign inst_rdata   = r_inst_rdata;
   assign data_rdata   = r_data_rdata;
   assign bus_req      = r_bus_req;
   assign bus_wr       = r_bus_wr;
   assign bus_wstrb    = r_bus_wstrb;
   assign bus_addr     = r_bus_addr;
   assign bus_wdata    = r_bus_wdata;
   assign bus_err      = r_bus_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_INST;
         r_bus_req    <= 1'b0;
         r_bus_wr     <= 1'b0;
         r_bus_wstrb  <= '0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
         r_inst_dok   <= 1'b0;
         r_data_dok   <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_inst_dok <= 1'b0;
         r_data_dok <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_gnt_i | w_gnt_d) begin
                  r_owner     <= w_gnt_d ? OWN_DATA : OWN_INST;
                  r_bus_wr    <= w_gnt_d & data_wr;
                  r_bus_wstrb <= w_gnt_d ? data_wstrb : '0;
                  r_bus_addr  <= w_gnt_d ? data_addr : inst_addr;
                  r_bus_wdata <= w_gnt_d ? data_wdata : '0;
                  r_bus_req   <= 1'b1;
                  r_state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               // data_ok before the address phase closes is a slave bug
               if (bus_data_ok) r_bus_err <= 1'b1;
               if (bus_addr_ok) begin
                  r_bus_req <= 1'b0;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus_data_ok) begin
                  if (r_owner == OWN_DATA) begin
                     r_data_rdata <= r_bus_wr ? '0 : bus_rdata;
                     r_data_dok   <= 1'b1;
                  end else begin
                     r_inst_rdata <= bus_rdata;
                     r_inst_dok   <= 1'b1;
                  end
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starve <= '0;
      end else if (w_gnt_i) begin
         r_starve <= '0;
      end else if (w_gnt_d) begin
         if (!inst_req)           r_starve <= '0;
         else if (r_starve != LIM) r_starve <= r_starve + 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a small SRAM-like slave
// model and a grant-order scoreboard of expected responses.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [3:0]  data_wstrb = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        bus_err;

   sram_bus_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      if (a == 32'h1C00_0000) return 32'h0280_0C0C;
      return {a[15:0], ~a[15:0]};
   endfunction

   // slave: addr_ok after s_wait cycles of bus_req, data_ok one cycle later
   logic        s_pend = 1'b0;
   logic [31:0] s_rd = '0;
   int          s_cnt = 0;
   int          s_wait = 0;
   logic        s_err = 1'b0;
   logic        s_hold = 1'b0;

   assign bus_addr_ok = bus_req && (s_cnt == s_wait);
   assign bus_data_ok = (s_pend & ~s_hold) | (s_err & bus_addr_ok);
   assign bus_rdata   = (s_pend & ~s_hold) ? s_rd : 32'h0BAD_0BAD;

   always @(posedge clk) begin
      if (s_pend && !s_hold) s_pend <= 1'b0;
      if (bus_req && bus_addr_ok) begin
         s_pend <= 1'b1;
         s_rd   <= bus_wr ? 32'hFFFF_FFFF : slave_data(bus_addr);
         s_cnt  <= 0;
      end else if (bus_req) begin
         s_cnt <= s_cnt + 1;
      end else begin
         s_cnt <= 0;
      end
   end

   typedef struct {
      logic        own;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   bit   gseq[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_resp = 0;
   logic g_i, g_d;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      g_i = inst_addr_ok;
      g_d = data_addr_ok;
      if (g_i) begin
         sb.push_back('{1'b0, slave_data(inst_addr)});
         gseq.push_back(1'b0);
      end
      if (g_d) begin
         sb.push_back('{1'b1, data_wr ? 32'h0 : slave_data(data_addr)});
         gseq.push_back(1'b1);
      end
      @(posedge clk);
      #1;
      if (inst_data_ok || data_data_ok) begin
         n_resp++;
         chk("resp_single", 64'(inst_data_ok & data_data_ok), 64'd0);
         chk("resp_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_owner", 64'(data_data_ok), 64'(e.own));
            chk("resp_rdata", 64'(data_data_ok ? data_rdata : inst_rdata),
                64'(e.rd));
         end
      end
   endtask

   task automatic wait_grant();
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = g_i | g_d;
      end
      chk("grant_seen", 64'(got), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int r0;
      int cyc;
      bit exp_seq [6];
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      // reset state
      tick();
      tick();
      chk("rst_bus_req", 64'(bus_req), 64'd0);
      chk("rst_bus_wr", 64'(bus_wr), 64'd0);
      chk("rst_bus_fields", {bus_addr, bus_wdata}, 64'd0);
      chk("rst_wstrb", 64'(bus_wstrb), 64'd0);
      chk("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
      chk("rst_dok", 64'({inst_data_ok, data_data_ok}), 64'd0);
      chk("rst_err", 64'(bus_err), 64'd0);
      resetn = 1'b1;
      tick();

      // single inst read, zero-wait slave
      inst_req = 1'b1;
      inst_addr = 32'h1C00_0000;
      wait_grant();
      r0 = n_resp;
      chk("i_grant_is_inst", 64'(g_i), 64'd1);
      inst_req = 1'b0;
      chk("i_c1_bus_req", 64'(bus_req), 64'd1);
      chk("i_c1_bus_wr", 64'(bus_wr), 64'd0);
      chk("i_c1_bus_addr", 64'(bus_addr), 64'h1C00_0000);
      tick();
      tick();
      chk("i_c3_data_ok", 64'(inst_data_ok), 64'd1);
      chk("i_c3_rdata", 64'(inst_rdata), 64'h0280_0C0C);
      chk("i_c3_resp_cnt", 64'(n_resp - r0), 64'd1);
      tick();
      chk("i_c4_data_ok_low", 64'(inst_data_ok), 64'd0);
      chk("i_rdata_held", 64'(inst_rdata), 64'h0280_0C0C);

      // store with two slave wait cycles; upstream changes after grant
      s_wait = 2;
      data_req = 1'b1;
      data_wr = 1'b1;
      data_wstrb = 4'b0011;
      data_addr = 32'h0000_1000;
      data_wdata = 32'hDEAD_BEEF;
      wait_grant();
      chk("st_grant_is_data", 64'(g_d), 64'd1);
      data_req = 1'b0;
      data_wr = 1'b0;
      data_wstrb = 4'hF;
      data_addr = 32'hFFFF_0000;
      data_wdata = '0;
      cyc = 0;
      for (int i = 0; i < 10 && bus_req; i++) begin
         cyc++;
         chk("st_bus_wr", 64'(bus_wr), 64'd1);
         chk("st_bus_wstrb", 64'(bus_wstrb), 64'h3);
         chk("st_bus_addr", 64'(bus_addr), 64'h1000);
         chk("st_bus_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
         tick();
      end
      chk("st_req_cycles", 64'(cyc), 64'd3);
      drain();
      chk("st_rdata_zero", 64'(data_rdata), 64'd0);
      s_wait = 0;

      // simultaneous requests: data first, then inst
      gseq.delete();
      r0 = n_resp;
      inst_req = 1'b1;
      inst_addr = 32'h1C00_0004;
      data_req = 1'b1;
      data_addr = 32'h0000_3000;
      wait_grant();
      data_req = 1'b0;
      wait_grant();
      inst_req = 1'b0;
      drain();
      chk("sim_grants", 64'(gseq.size()), 64'd2);
      if (gseq.size() == 2) begin
         chk("sim_first_data", 64'(gseq[0]), 64'd1);
         chk("sim_second_inst", 64'(gseq[1]), 64'd0);
      end
      chk("sim_resp_cnt", 64'(n_resp - r0), 64'd2);

      // starvation guard: both held through six grants
      gseq.delete();
      inst_req = 1'b1;
      inst_addr = 32'h1C00_0008;
      data_req = 1'b1;
      data_addr = 32'h0000_4000;
      for (int i = 0; i < 80 && gseq.size() < 6; i++) tick();
      inst_req = 1'b0;
      data_req = 1'b0;
      chk("stv_grants", 64'(gseq.size()), 64'd6);
      for (int i = 0; i < 6 && i < gseq.size(); i++)
         chk($sformatf("stv_grant%0d", i), 64'(gseq[i]), 64'(exp_seq[i]));
      drain();

      // reset while the address phase is open
      s_wait = 5;
      data_req = 1'b1;
      data_addr = 32'h0000_5000;
      wait_grant();
      data_req = 1'b0;
      chk("rq_bus_req_before", 64'(bus_req), 64'd1);
      resetn = 1'b0;
      #1;
      chk("rq_bus_req_rst", 64'(bus_req), 64'd0);
      sb.delete();
      tick();
      resetn = 1'b1;
      s_wait = 0;
      tick();

      // reset in WAIT, then a stale data_ok afterwards
      s_hold = 1'b1;
      data_req = 1'b1;
      data_addr = 32'h0000_6000;
      wait_grant();
      data_req = 1'b0;
      tick();
      tick();
      resetn = 1'b0;
      #1;
      chk("rw_bus_req", 64'(bus_req), 64'd0);
      chk("rw_dok", 64'({inst_data_ok, data_data_ok}), 64'd0);
      sb.delete();
      tick();
      resetn = 1'b1;
      r0 = n_resp;
      s_hold = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("rw_stale_no_resp", 64'(n_resp - r0), 64'd0);
      chk("rw_stale_no_err", 64'(bus_err), 64'd0);

      // protocol error: data_ok together with addr_ok
      s_err = 1'b1;
      inst_req = 1'b1;
      inst_addr = 32'h0000_0040;
      wait_grant();
      inst_req = 1'b0;
      tick();
      s_err = 1'b0;
      chk("pe_err_set", 64'(bus_err), 64'd1);
      r0 = n_resp;
      drain();
      chk("pe_resp_cnt", 64'(n_resp - r0), 64'd1);
      chk("pe_rdata", 64'(inst_rdata), 64'(slave_data(32'h40)));
      for (int i = 0; i < 3; i++) tick();
      chk("pe_err_sticky", 64'(bus_err), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
